// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller slice.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DIV      = 2'd1,
    S_EXC_PEND = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Operand select for one EX source; the younger MEM result wins over WB.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] wr_m,
    input logic       en_m,
    input logic [4:0] wr_w,
    input logic       en_w
  );
    if (en_m && wr_m != 5'd0 && wr_m == src)      return FWD_M;
    else if (en_w && wr_w != 5'd0 && wr_w == src) return FWD_W;
    else                                          return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// EX-stage operand forwarding selects (purely combinational).
module forward_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       rst,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       reg_write_enM,
  input  logic       reg_write_enW,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE
);

  // Select per operand; forced to the register file while in reset.
  always_comb begin
    forwardAE = FWD_RF;
    forwardBE = FWD_RF;
    if (!rst) begin
      forwardAE = fwd_sel(rsE, writeregM, reg_write_enM, writeregW, reg_write_enW);
      forwardBE = fwd_sel(rtE, writeregM, reg_write_enM, writeregW, reg_write_enW);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: forwarding, load-use bubble, divider freeze,
// and exception flush deferred until both memories are idle.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 36,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       reg_write_enE,
  input  logic       reg_write_enM,
  input  logic       reg_write_enW,
  input  logic       mem_to_regE,
  input  logic       div_startE,
  input  logic       branch_flushE,
  input  logic       exceptionM,
  input  logic       i_stall,
  input  logic       d_stall,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       stallW,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic       exc_flush,
  output logic       div_ready
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_busy, lwstall, long_stall, div_stall, div_rdy, exc_take;

  // reg_write_enE is not needed: a load in EX always writes its destination.
  logic unused_en;
  assign unused_en = reg_write_enE;

  forward_unit u_fwd (
    .rst           (rst),
    .rsE           (rsE),
    .rtE           (rtE),
    .writeregM     (writeregM),
    .writeregW     (writeregW),
    .reg_write_enM (reg_write_enM),
    .reg_write_enW (reg_write_enW),
    .forwardAE     (forwardAE),
    .forwardBE     (forwardBE)
  );

  assign mem_busy = i_stall | d_stall;
  assign lwstall  = mem_to_regE && writeregE != 5'd0 &&
                    (writeregE == rsD || writeregE == rtD);

  // State and divide counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state plus stall/flush mux; exception flush outranks every stall.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_stall = 1'b0;
    div_rdy   = 1'b0;
    exc_take  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (exceptionM) begin
          if (mem_busy) state_d = S_EXC_PEND;
          else          exc_take = 1'b1;
        end else if (div_startE) begin
          div_stall = 1'b1;
          cnt_d     = CNT_W'(DIV_CYCLES - 1);
          state_d   = S_DIV;
        end
      end
      S_DIV: begin
        if (exceptionM) begin
          // Abort the divide; the exception is handled as from IDLE.
          cnt_d = '0;
          if (mem_busy) state_d = S_EXC_PEND;
          else begin
            exc_take = 1'b1;
            state_d  = S_IDLE;
          end
        end else if (cnt_q != '0) begin
          div_stall = 1'b1;
          cnt_d     = cnt_q - CNT_W'(1);
        end else begin
          // Result held until EX is free to move it on.
          div_rdy = 1'b1;
          if (!mem_busy) state_d = S_IDLE;
        end
      end
      S_EXC_PEND: begin
        if (!mem_busy) begin
          exc_take = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    long_stall = mem_busy | div_stall;

    stallF = 1'b0; stallD = 1'b0; stallE = 1'b0; stallM = 1'b0; stallW = 1'b0;
    flushD = 1'b0; flushE = 1'b0; flushM = 1'b0; flushW = 1'b0;
    exc_flush = 1'b0;
    div_ready = 1'b0;
    if (!rst) begin
      div_ready = div_rdy;
      if (exc_take) begin
        {flushD, flushE, flushM, flushW} = 4'hF;
        exc_flush = 1'b1;
      end else if (long_stall) begin
        {stallF, stallD, stallE, stallM, stallW} = 5'h1F;
      end else if (lwstall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end else if (branch_flushE) begin
        flushD = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table plus multi-cycle sequences,
// expected outputs queued at drive time and popped at the sampling edge.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
    logic       enE, enM, enW, m2r, div, br, exc, ist, dst;
  } in_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic [4:0] st;   // F D E M W
    logic [3:0] fl;   // D E M W
    logic       xf, dr;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  o;
    string nm;
  } vec_t;

  logic  clk = 1'b0;
  in_t   cur;
  out_t  act;
  out_t  expq[$];
  string nameq[$];
  int    checks = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DIV_CYCLES(36), .CNT_W(6)) dut (
    .clk(clk), .rst(cur.rst),
    .rsD(cur.rsD), .rtD(cur.rtD), .rsE(cur.rsE), .rtE(cur.rtE),
    .writeregE(cur.wE), .writeregM(cur.wM), .writeregW(cur.wW),
    .reg_write_enE(cur.enE), .reg_write_enM(cur.enM), .reg_write_enW(cur.enW),
    .mem_to_regE(cur.m2r), .div_startE(cur.div), .branch_flushE(cur.br),
    .exceptionM(cur.exc), .i_stall(cur.ist), .d_stall(cur.dst),
    .forwardAE(act.fa), .forwardBE(act.fb),
    .stallF(act.st[4]), .stallD(act.st[3]), .stallE(act.st[2]),
    .stallM(act.st[1]), .stallW(act.st[0]),
    .flushD(act.fl[3]), .flushE(act.fl[2]), .flushM(act.fl[1]), .flushW(act.fl[0]),
    .exc_flush(act.xf), .div_ready(act.dr)
  );

  function automatic in_t zi();
    in_t r = '0;
    return r;
  endfunction

  function automatic out_t eo(logic [1:0] fa, logic [1:0] fb, logic [4:0] st,
                              logic [3:0] fl, logic xf, logic dr);
    out_t r;
    r.fa = fa; r.fb = fb; r.st = st; r.fl = fl; r.xf = xf; r.dr = dr;
    return r;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare at negedge.
  task automatic step(input in_t i, input out_t e, input string nm);
    out_t  ex;
    string n;
    @(posedge clk); #1;
    cur = i;
    expq.push_back(e);
    nameq.push_back(nm);
    @(negedge clk);
    ex = expq.pop_front();
    n  = nameq.pop_front();
    checks++;
    if (act !== ex) begin
      failures++;
      $display("FAIL %s: got fa=%b fb=%b st=%b fl=%b xf=%b dr=%b, want fa=%b fb=%b st=%b fl=%b xf=%b dr=%b",
               n, act.fa, act.fb, act.st, act.fl, act.xf, act.dr,
               ex.fa, ex.fb, ex.st, ex.fl, ex.xf, ex.dr);
    end
  endtask

  vec_t vt[12];
  in_t  t;
  out_t Z;

  initial begin
    Z = '0;
    cur = zi();
    cur.rst = 1'b1;

    // Forwarding hazards present while in reset must not leak out.
    t = zi(); t.rst = 1; t.enM = 1; t.wM = 5'd3; t.rsE = 5'd3; t.div = 1; t.m2r = 1; t.wE = 5'd7; t.rsD = 5'd7;
    step(t, Z, "reset_outputs");
    step(t, Z, "reset_outputs2");

    // Single-cycle vectors from IDLE.
    t = zi(); t.enM = 1; t.wM = 3; t.enW = 1; t.wW = 3; t.rsE = 3; t.rtE = 4;
    vt[0] = '{t, eo(2'b10, 2'b00, 5'h00, 4'h0, 0, 0), "fwdA_mem_prio"};
    t.wM = 0;
    vt[1] = '{t, eo(2'b01, 2'b00, 5'h00, 4'h0, 0, 0), "fwdA_wb_when_m_zero"};
    t.wM = 3; t.rsE = 0;
    vt[2] = '{t, eo(2'b00, 2'b00, 5'h00, 4'h0, 0, 0), "fwdA_r0"};
    t = zi(); t.enM = 0; t.wM = 9; t.enW = 1; t.wW = 9; t.rsE = 9; t.rtE = 9;
    vt[3] = '{t, eo(2'b01, 2'b01, 5'h00, 4'h0, 0, 0), "fwd_both_wb_m_disabled"};
    t = zi(); t.enM = 1; t.wM = 6; t.rtE = 6; t.rsE = 2;
    vt[4] = '{t, eo(2'b00, 2'b10, 5'h00, 4'h0, 0, 0), "fwdB_mem"};
    t = zi(); t.m2r = 1; t.wE = 5; t.rtD = 5;
    vt[5] = '{t, eo(2'b00, 2'b00, 5'b11000, 4'b0100, 0, 0), "lwstall_bubble"};
    t = zi();
    vt[6] = '{t, Z, "after_lwstall_clear"};
    t = zi(); t.m2r = 1; t.wE = 0; t.rsD = 0;
    vt[7] = '{t, Z, "lw_r0_no_stall"};
    t = zi(); t.br = 1;
    vt[8] = '{t, eo(2'b00, 2'b00, 5'h00, 4'b1000, 0, 0), "branch_flushD"};
    t.ist = 1;
    vt[9] = '{t, eo(2'b00, 2'b00, 5'h1F, 4'h0, 0, 0), "branch_under_istall"};
    t.ist = 0;
    vt[10] = '{t, eo(2'b00, 2'b00, 5'h00, 4'b1000, 0, 0), "branch_after_istall"};
    t = zi(); t.m2r = 1; t.wE = 5; t.rsD = 5; t.dst = 1;
    vt[11] = '{t, eo(2'b00, 2'b00, 5'h1F, 4'h0, 0, 0), "lwstall_under_dstall"};
    for (int k = 0; k < 12; k++) step(vt[k].i, vt[k].o, vt[k].nm);

    // Exception in IDLE with memories idle: immediate flush, lwstall suppressed.
    t = zi(); t.exc = 1; t.m2r = 1; t.wE = 5; t.rtD = 5;
    step(t, eo(0, 0, 5'h00, 4'hF, 1, 0), "exc_immediate");
    step(zi(), Z, "exc_immediate_after");

    // Divide: 36 stalled cycles, ready in cycle 36, no restart afterwards.
    t = zi(); t.div = 1;
    for (int c = 0; c < 36; c++) step(t, eo(0, 0, 5'h1F, 4'h0, 0, 0), $sformatf("div_stall_c%0d", c));
    step(t, eo(0, 0, 5'h00, 4'h0, 0, 1), "div_ready_c36");
    step(zi(), Z, "div_no_restart");

    // Deferred exception: d_stall for 3 cycles, second exception ignored.
    t = zi(); t.exc = 1; t.dst = 1;
    step(t, eo(0, 0, 5'h1F, 4'h0, 0, 0), "exc_pend_c0");
    step(t, eo(0, 0, 5'h1F, 4'h0, 0, 0), "exc_pend_c1");
    t.exc = 0;
    step(t, eo(0, 0, 5'h1F, 4'h0, 0, 0), "exc_pend_c2");
    step(zi(), eo(0, 0, 5'h00, 4'hF, 1, 0), "exc_pend_release");
    step(zi(), Z, "exc_pend_one_shot");

    // Exception aborts a divide in progress.
    t = zi(); t.div = 1;
    for (int c = 0; c < 3; c++) step(t, eo(0, 0, 5'h1F, 4'h0, 0, 0), "abort_div_stall");
    t.exc = 1;
    step(t, eo(0, 0, 5'h00, 4'hF, 1, 0), "abort_div_flush");
    step(zi(), Z, "abort_div_idle");

    // Divide ready held while d_stall freezes EX.
    t = zi(); t.div = 1;
    for (int c = 0; c < 36; c++) step(t, eo(0, 0, 5'h1F, 4'h0, 0, 0), "div2_stall");
    t.dst = 1;
    step(t, eo(0, 0, 5'h1F, 4'h0, 0, 1), "div2_ready_held");
    t.dst = 0;
    step(t, eo(0, 0, 5'h00, 4'h0, 0, 1), "div2_ready_release");
    step(zi(), Z, "div2_idle");

    // Reset in cycle 10 of a divide.
    t = zi(); t.div = 1;
    for (int c = 0; c < 10; c++) step(t, eo(0, 0, 5'h1F, 4'h0, 0, 0), "rstdiv_stall");
    t.rst = 1;
    step(t, Z, "rstdiv_in_reset");
    step(zi(), Z, "rstdiv_idle");
    step(zi(), Z, "rstdiv_idle2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
